// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan driver: hex/decimal decode, per-digit dp/blank,
// 16-level PWM brightness, frame-coherent input snapshot and frame-done strobe.

module seg_dec (
    input  logic       hex_mode,
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = hex_mode ? 7'b1110111 : 7'h00;
            4'hB: seg = hex_mode ? 7'b0011111 : 7'h00;
            4'hC: seg = hex_mode ? 7'b1001110 : 7'h00;
            4'hD: seg = hex_mode ? 7'b0111101 : 7'h00;
            4'hE: seg = hex_mode ? 7'b1001111 : 7'h00;
            4'hF: seg = hex_mode ? 7'b1000111 : 7'h00;
        endcase
    end
endmodule

module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_HZ         = 50000000,
    parameter int SCAN_HZ        = 1000,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    nRESET,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    hex_mode,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   SEG_COM,
    output logic [7:0]              SEG_DATA,
    output logic                    frame_done
);
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int SLOT  = DIV / 16;
    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] COM_OFF = {NUM_DIGITS{COM_ACTIVE_LOW}};
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    first;
    logic [4*NUM_DIGITS-1:0] val_s;
    logic [NUM_DIGITS-1:0]   dp_s, blank_s;
    logic                    hex_s;

    logic                    tick, wrap, load;
    logic [3:0]              sub;
    logic [4*NUM_DIGITS-1:0] val_e;
    logic [NUM_DIGITS-1:0]   dp_e, blank_e;
    logic                    hex_e;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   com_nxt;
    logic [7:0]              data_nxt;

    assign tick = (div_cnt == DIV_W'(DIV - 1));
    assign wrap = tick && (idx == IDX_LAST);
    assign load = first | wrap;
    assign sub  = 4'(div_cnt / DIV_W'(SLOT));

    // The first cycle after reset has an empty shadow, so it shows the live inputs.
    assign val_e   = first ? value      : val_s;
    assign dp_e    = first ? dp_mask    : dp_s;
    assign blank_e = first ? blank_mask : blank_s;
    assign hex_e   = first ? hex_mode   : hex_s;
    assign nib     = val_e[{idx, 2'b00} +: 4];

    seg_dec u_dec (
        .hex_mode (hex_e),
        .nib      (nib),
        .seg      (seg)
    );

    always_comb begin
        com_nxt = COM_OFF;
        if (enable && (sub <= brightness))
            com_nxt[idx] = ~COM_ACTIVE_LOW;
        data_nxt = blank_e[idx] ? 8'h00 : {seg, dp_e[idx]};
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            div_cnt    <= '0;
            idx        <= '0;
            first      <= 1'b1;
            val_s      <= '0;
            dp_s       <= '0;
            blank_s    <= '0;
            hex_s      <= 1'b0;
            SEG_COM    <= COM_OFF;
            SEG_DATA   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            first   <= 1'b0;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (load) begin
                val_s   <= value;
                dp_s    <= dp_mask;
                blank_s <= blank_mask;
                hex_s   <= hex_mode;
            end
            frame_done <= wrap;
            SEG_COM    <= com_nxt;
            SEG_DATA   <= data_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Random + directed bench for seg_scan_ctrl against a cycle-count reference model.

module tb_seg_scan_ctrl;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic [15:0] value = 16'h3210;
    logic [3:0]  dp_mask = 4'h0, blank_mask = 4'h0, brightness = 4'hF;
    logic        hex_mode = 1'b0, enable = 1'b1;
    logic [3:0]  SEG_COM;
    logic [7:0]  SEG_DATA;
    logic        frame_done;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_HZ(1600), .SCAN_HZ(100), .COM_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .hex_mode   (hex_mode),
        .brightness (brightness),
        .enable     (enable),
        .SEG_COM    (SEG_COM),
        .SEG_DATA   (SEG_DATA),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int n = 0;  // clk edges since reset release
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blank;
    logic        m_hex;
    logic [6:0]  seg7 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    task automatic latch();
        m_val = value; m_dp = dp_mask; m_blank = blank_mask; m_hex = hex_mode;
    endtask

    task automatic chk_reset();
        chk("rst_com", 32'(SEG_COM), 32'h0000_000F);
        chk("rst_data", 32'(SEG_DATA), 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'h0);
    endtask

    // Cycle n of a frame: digit (n/16)%4, sub-slot n%16; frame data latched at
    // the first edge and at the last edge of every 64-clk frame.
    task automatic step();
        logic [3:0] ecom, nb;
        logic [7:0] edata;
        logic       efd;
        int d, ix;
        @(posedge clk);
        if (n == 0) latch();
        d  = n % 16;
        ix = (n / 16) % ND;
        ecom = 4'hF;
        if (enable && d <= int'(brightness)) ecom[ix] = 1'b0;
        nb = m_val[ix*4 +: 4];
        edata = m_blank[ix] ? 8'h00 : {((m_hex || nb < 4'd10) ? seg7[nb] : 7'h00), m_dp[ix]};
        efd = (n % 64) == 63;
        if (n % 64 == 63) latch();
        n++;
        #1;
        chk("com", 32'(SEG_COM), 32'(ecom));
        chk("data", 32'(SEG_DATA), 32'(edata));
        chk("fdone", 32'(frame_done), 32'(efd));
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    initial begin
        #23;
        chk_reset();
        @(negedge clk) nRESET = 1'b1;
        n = 0;
        run(128);                                     // 3210 decimal, full brightness

        value = 16'hFEDA; hex_mode = 1'b1; run(64);   // letters
        hex_mode = 1'b0; run(128);                    // A-F blank from next frame

        value = 16'h8888; dp_mask = 4'b0101; blank_mask = 4'b1000; run(64);

        value = 16'h3210; dp_mask = 4'h0; blank_mask = 4'h0;
        brightness = 4'd3; run(40);
        enable = 1'b0; run(30);
        enable = 1'b1; brightness = 4'd0; run(50);
        brightness = 4'd15;

        while ((n % 64) / 16 != 1) step();            // mid-frame change at digit 1
        run(5);
        value = 16'h7654; run(100);

        while ((n % 64) / 16 != 2) step();            // reset mid-scan at digit 2
        run(3);
        #2 nRESET = 1'b0;
        #1 chk_reset();
        @(negedge clk) nRESET = 1'b1;
        n = 0;
        run(70);

        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) value = 16'($urandom);
            if ($urandom_range(0, 29) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 39) == 0) hex_mode = ~hex_mode;
            if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
